// File: rtl/regfile_operand_stage_if.sv
// Bundle for the operand stage: decoded-instruction input, write-back port and
// the registered operand handshake toward the ALU.
interface regfile_operand_stage_if #(
    parameter int unsigned DATA_W    = 32,
    parameter int unsigned NREG_LOG2 = 5,
    parameter int unsigned IMM_W     = 16
);
    logic                 in_valid;
    logic                 in_ready;
    logic [NREG_LOG2-1:0] rs_addr;
    logic [NREG_LOG2-1:0] rt_addr;
    logic [IMM_W-1:0]     imm;
    logic                 alu_src;
    logic                 imm_zext;
    logic [2:0]           alu_sel_in;
    logic                 flush;
    logic                 wb_en;
    logic [NREG_LOG2-1:0] wb_addr;
    logic [DATA_W-1:0]    wb_data;
    logic                 out_valid;
    logic                 out_ready;
    logic [DATA_W-1:0]    A;
    logic [DATA_W-1:0]    B;
    logic [2:0]           ALU_Sel;

    modport master (
        output in_valid, rs_addr, rt_addr, imm, alu_src, imm_zext, alu_sel_in, flush,
               wb_en, wb_addr, wb_data, out_ready,
        input  in_ready, out_valid, A, B, ALU_Sel
    );

    modport slave (
        input  in_valid, rs_addr, rt_addr, imm, alu_src, imm_zext, alu_sel_in, flush,
               wb_en, wb_addr, wb_data, out_ready,
        output in_ready, out_valid, A, B, ALU_Sel
    );
endinterface

// File: rtl/regfile_operand_stage.sv
// 32x32 register file with write-back bypass, immediate extension and a
// one-entry valid/ready operand register feeding the ALU.
module regfile_operand_stage #(
    parameter int unsigned DATA_W    = 32,
    parameter int unsigned NREG_LOG2 = 5,
    parameter int unsigned IMM_W     = 16
) (
    input logic                   clk,
    input logic                   rst_n,
    regfile_operand_stage_if.slave bus
);
    localparam int NumRegs = 2 ** NREG_LOG2;

    // r0 has no storage; it is decoded to zero on read.
    logic [DATA_W-1:0] regs [1:NumRegs-1];

    logic [DATA_W-1:0] rs_val;
    logic [DATA_W-1:0] rt_val;
    logic [DATA_W-1:0] imm_ext;
    logic [DATA_W-1:0] b_sel;
    logic              in_ready;
    logic              capture;

    logic [DATA_W-1:0] a_q;
    logic [DATA_W-1:0] b_q;
    logic [2:0]        sel_q;
    logic              valid_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 1; i < NumRegs; i++) begin
                regs[i] <= '0;
            end
        end else if (bus.wb_en && bus.wb_addr != '0) begin
            regs[bus.wb_addr] <= bus.wb_data;
        end
    end

    always_comb begin
        rs_val = '0;
        rt_val = '0;
        if (bus.rs_addr != '0) begin
            if (bus.wb_en && bus.wb_addr == bus.rs_addr) rs_val = bus.wb_data;
            else                                         rs_val = regs[bus.rs_addr];
        end
        if (bus.rt_addr != '0) begin
            if (bus.wb_en && bus.wb_addr == bus.rt_addr) rt_val = bus.wb_data;
            else                                         rt_val = regs[bus.rt_addr];
        end
    end

    always_comb begin
        imm_ext = bus.imm_zext ? {{(DATA_W-IMM_W){1'b0}}, bus.imm}
                               : {{(DATA_W-IMM_W){bus.imm[IMM_W-1]}}, bus.imm};
        b_sel   = bus.alu_src ? imm_ext : rt_val;
    end

    assign in_ready = ~valid_q | bus.out_ready;
    assign capture  = bus.in_valid & in_ready & ~bus.flush;

    // Operand payload only loads on capture, so a held set ignores later write-backs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q     <= '0;
            b_q     <= '0;
            sel_q   <= 3'b000;
            valid_q <= 1'b0;
        end else if (capture) begin
            a_q     <= rs_val;
            b_q     <= b_sel;
            sel_q   <= bus.alu_sel_in;
            valid_q <= 1'b1;
        end else if (bus.flush || bus.out_ready) begin
            valid_q <= 1'b0;
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = valid_q;
    assign bus.A         = a_q;
    assign bus.B         = b_q;
    assign bus.ALU_Sel   = sel_q;
endmodule

// File: tb/tb_regfile_operand_stage.sv
// Directed bench: expected operand sets are queued at issue time and a negedge
// monitor compares them whenever the DUT hands an operand set to the ALU side.
module tb_regfile_operand_stage;
    typedef struct packed {
        logic [31:0] a;
        logic [31:0] b;
        logic [2:0]  sel;
    } exp_t;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_fail;
    exp_t sb[$];

    regfile_operand_stage_if #(.DATA_W(32), .NREG_LOG2(5), .IMM_W(16)) bus ();

    regfile_operand_stage #(.DATA_W(32), .NREG_LOG2(5), .IMM_W(16)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic push(input logic [31:0] a, input logic [31:0] b, input logic [2:0] sel);
        exp_t e;
        e.a   = a;
        e.b   = b;
        e.sel = sel;
        sb.push_back(e);
    endtask

    task automatic issue(input logic [4:0] rs, input logic [4:0] rt, input logic [15:0] im,
                         input logic src, input logic zx, input logic [2:0] sel);
        bus.in_valid   = 1'b1;
        bus.rs_addr    = rs;
        bus.rt_addr    = rt;
        bus.imm        = im;
        bus.alu_src    = src;
        bus.imm_zext   = zx;
        bus.alu_sel_in = sel;
    endtask

    task automatic wb(input logic [4:0] addr, input logic [31:0] data);
        bus.wb_en   = 1'b1;
        bus.wb_addr = addr;
        bus.wb_data = data;
    endtask

    task automatic idle();
        bus.in_valid = 1'b0;
        bus.wb_en    = 1'b0;
        bus.flush    = 1'b0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin : monitor
        exp_t e;
        if (rst_n === 1'b1 && bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
            if (sb.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_output: got A=0x%08h B=0x%08h, expected no transfer",
                         bus.A, bus.B);
            end else begin
                e = sb.pop_front();
                check("out_A", bus.A, e.a);
                check("out_B", bus.B, e.b);
                check("out_ALU_Sel", {29'd0, bus.ALU_Sel}, {29'd0, e.sel});
            end
        end
    end

    initial begin : watchdog
        #100000;
        $display("FAIL timeout: got no finish, expected finish before 100000 time units");
        $fatal(1, "watchdog expired");
    end

    initial begin
        n_checks      = 0;
        n_fail        = 0;
        rst_n         = 1'b0;
        bus.out_ready = 1'b1;
        bus.rs_addr   = '0;
        bus.rt_addr   = '0;
        bus.imm       = '0;
        bus.alu_src   = 1'b0;
        bus.imm_zext  = 1'b0;
        bus.alu_sel_in = '0;
        bus.wb_addr   = '0;
        bus.wb_data   = '0;
        idle();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        // Hold an operand set, then reset mid-cycle: it must vanish at once.
        bus.out_ready = 1'b0;
        issue(5'd0, 5'd0, 16'h1234, 1'b1, 1'b1, 3'd5);
        step();
        idle();
        check("held_valid_pre_reset", {31'd0, bus.out_valid}, 32'd1);
        check("held_B_pre_reset", bus.B, 32'h0000_1234);
        #3 rst_n = 1'b0;
        #1;
        check("reset_out_valid", {31'd0, bus.out_valid}, 32'd0);
        check("reset_A", bus.A, 32'd0);
        check("reset_B", bus.B, 32'd0);
        check("reset_ALU_Sel", {29'd0, bus.ALU_Sel}, 32'd0);
        check("reset_in_ready", {31'd0, bus.in_ready}, 32'd1);
        @(posedge clk);
        #1 rst_n = 1'b1;
        bus.out_ready = 1'b1;

        // Cleared register file reads zero.
        issue(5'd5, 5'd5, 16'h0000, 1'b0, 1'b0, 3'd0);
        push(32'd0, 32'd0, 3'd0);
        step();
        idle();

        // Write then read.
        wb(5'd3, 32'h0000_00AA);
        step();
        idle();
        issue(5'd3, 5'd3, 16'h0000, 1'b0, 1'b0, 3'd1);
        push(32'h0000_00AA, 32'h0000_00AA, 3'd1);
        step();
        idle();

        // Same-cycle bypass; r0 stays zero.
        issue(5'd7, 5'd0, 16'h0000, 1'b0, 1'b0, 3'd2);
        wb(5'd7, 32'h1234_5678);
        push(32'h1234_5678, 32'd0, 3'd2);
        step();
        idle();
        issue(5'd0, 5'd0, 16'h0000, 1'b0, 1'b0, 3'd3);
        wb(5'd0, 32'hFFFF_FFFF);
        push(32'd0, 32'd0, 3'd3);
        step();
        idle();
        issue(5'd0, 5'd0, 16'h0000, 1'b0, 1'b0, 3'd4);
        push(32'd0, 32'd0, 3'd4);
        step();

        // Immediate extension, back-to-back.
        issue(5'd7, 5'd3, 16'h8001, 1'b1, 1'b0, 3'd4);
        push(32'h1234_5678, 32'hFFFF_8001, 3'd4);
        step();
        issue(5'd7, 5'd3, 16'h8001, 1'b1, 1'b1, 3'd5);
        push(32'h1234_5678, 32'h0000_8001, 3'd5);
        step();
        idle();
        step();

        // Backpressure: held set frozen while r3 is rewritten.
        bus.out_ready = 1'b0;
        issue(5'd3, 5'd7, 16'h0000, 1'b0, 1'b0, 3'd6);
        push(32'h0000_00AA, 32'h1234_5678, 3'd6);
        step();
        issue(5'd3, 5'd7, 16'h0000, 1'b0, 1'b0, 3'd7);
        wb(5'd3, 32'hDEAD_BEEF);
        for (int i = 0; i < 3; i++) begin
            check("hold_in_ready", {31'd0, bus.in_ready}, 32'd0);
            check("hold_out_valid", {31'd0, bus.out_valid}, 32'd1);
            check("hold_A", bus.A, 32'h0000_00AA);
            check("hold_B", bus.B, 32'h1234_5678);
            step();
            bus.wb_en = 1'b0;
        end
        bus.out_ready = 1'b1;
        push(32'hDEAD_BEEF, 32'h1234_5678, 3'd7);
        step();
        idle();
        step();

        // Flush drops the held set and the incoming one; write-back still lands.
        bus.out_ready = 1'b0;
        issue(5'd0, 5'd0, 16'h0011, 1'b1, 1'b1, 3'd1);
        step();
        check("pre_flush_valid", {31'd0, bus.out_valid}, 32'd1);
        issue(5'd3, 5'd3, 16'h0000, 1'b0, 1'b0, 3'd2);
        bus.flush = 1'b1;
        wb(5'd4, 32'h0000_0055);
        step();
        idle();
        check("flush_out_valid", {31'd0, bus.out_valid}, 32'd0);
        check("flush_in_ready", {31'd0, bus.in_ready}, 32'd1);
        bus.out_ready = 1'b1;
        issue(5'd4, 5'd4, 16'h0000, 1'b0, 1'b0, 3'd2);
        push(32'h0000_0055, 32'h0000_0055, 3'd2);
        step();
        idle();
        repeat (3) step();

        check("scoreboard_drained", sb.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
